// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode/memory/execute bundle for instruction_fetch.
// master = fetch stage side, slave = decode/execute/memory environment side.
interface instruction_fetch_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 16
);
  logic                   stall_id;
  logic                   redirect_ex;
  logic [PC_WIDTH-1:0]    redirect_target_ex;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] instruction_if;
  logic [PC_WIDTH-1:0]    next_program_counter_if;
  logic                   branch_prediction_bp;

  modport master (
    input  stall_id, redirect_ex, redirect_target_ex, imem_rdata,
    output imem_addr, instruction_if, next_program_counter_if, branch_prediction_bp
  );

  modport slave (
    output stall_id, redirect_ex, redirect_target_ex, imem_rdata,
    input  imem_addr, instruction_if, next_program_counter_if, branch_prediction_bp
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, 1-cycle synchronous imem, 2-entry skid FIFO, execute redirects.
// Optional FETCH_JUMP_PREDICT_EN: redirect fetch when a JUMP_OPCODE word is output.
module instruction_fetch #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 16,
`ifdef FETCH_JUMP_PREDICT_EN
  parameter logic [3:0]          JUMP_OPCODE = 4'b1111,
`endif
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instruction_fetch_if.master bus
);

  logic [PC_WIDTH-1:0]         r_pc;
  logic                        r_req_new;
  logic                        r_inflight_v;
  logic [PC_WIDTH-1:0]         r_inflight_pc;
  logic [1:0][PC_WIDTH-1:0]    r_fifo_pc;
  logic [1:0][INSTR_WIDTH-1:0] r_fifo_data;
  logic [1:0]                  r_count;
  logic                        r_valid;
  logic [INSTR_WIDTH-1:0]      r_instr;
  logic [PC_WIDTH-1:0]         r_npc;

  logic                        w_fifo_empty;
  logic                        w_avail;
  logic [PC_WIDTH-1:0]         w_head_pc;
  logic [INSTR_WIDTH-1:0]      w_head_data;
  logic                        w_load;
  logic                        w_pop;
  logic                        w_push;
  logic                        w_jump;
  logic [PC_WIDTH-1:0]         w_jump_target;
  logic                        w_advance;
  logic                        w_flush;
  logic                        w_overflow;
  logic [PC_WIDTH-1:0]         w_pc_n;
  logic [1:0][PC_WIDTH-1:0]    w_fifo_pc_n;
  logic [1:0][INSTR_WIDTH-1:0] w_fifo_data_n;
  logic [1:0]                  w_count_n;

  assign w_fifo_empty = (r_count == 2'd0);
  assign w_avail      = !w_fifo_empty || r_inflight_v;
  assign w_head_pc    = w_fifo_empty ? r_inflight_pc  : r_fifo_pc[0];
  assign w_head_data  = w_fifo_empty ? bus.imem_rdata : r_fifo_data[0];

  // The response bypasses the FIFO only when it is the word being loaded.
  assign w_load = !bus.redirect_ex && !bus.stall_id && w_avail;
  assign w_pop  = w_load && !w_fifo_empty;
  assign w_push = r_inflight_v && !(w_load && w_fifo_empty);

`ifdef FETCH_JUMP_PREDICT_EN
  localparam int PadW = PC_WIDTH - 12;
  assign w_jump        = w_load && (w_head_data[INSTR_WIDTH-1 -: 4] == JUMP_OPCODE);
  assign w_jump_target = {{PadW{1'b0}}, w_head_data[11:0]};
`else
  assign w_jump        = 1'b0;
  assign w_jump_target = '0;
`endif

  assign w_flush   = bus.redirect_ex || w_jump;
  assign w_advance = !bus.stall_id && !bus.redirect_ex &&
                     (({1'b0, r_count} + {2'b00, r_inflight_v}) < 3'd2);

  always_comb begin
    w_pc_n = r_pc;
    if (bus.redirect_ex)
      w_pc_n = bus.redirect_target_ex;
    else if (w_jump)
      w_pc_n = w_jump_target;
    else if (w_advance)
      w_pc_n = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  end

  // Head pops first; the push then lands in the first free slot.
  always_comb begin
    w_fifo_pc_n   = r_fifo_pc;
    w_fifo_data_n = r_fifo_data;
    w_count_n     = r_count;
    if (w_flush) begin
      w_count_n = 2'd0;
    end else begin
      if (w_pop) begin
        w_fifo_pc_n[0]   = r_fifo_pc[1];
        w_fifo_data_n[0] = r_fifo_data[1];
        w_count_n        = r_count - 2'd1;
      end
      if (w_push) begin
        w_fifo_pc_n[w_count_n[0]]   = r_inflight_pc;
        w_fifo_data_n[w_count_n[0]] = bus.imem_rdata;
        w_count_n                   = w_count_n + 2'd1;
      end
    end
  end

  assign w_overflow = w_push && !w_pop && !w_flush && (r_count == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_req_new     <= 1'b1;
      r_inflight_v  <= 1'b0;
      r_inflight_pc <= '0;
      r_fifo_pc     <= '0;
      r_fifo_data   <= '0;
      r_count       <= 2'd0;
      r_valid       <= 1'b0;
      r_instr       <= '0;
      r_npc         <= '0;
    end else begin
      r_pc          <= w_pc_n;
      r_req_new     <= bus.redirect_ex || w_jump || w_advance;
      r_inflight_v  <= w_flush ? 1'b0 : r_req_new;
      r_inflight_pc <= r_pc;
      r_fifo_pc     <= w_fifo_pc_n;
      r_fifo_data   <= w_fifo_data_n;
      r_count       <= w_count_n;
      if (bus.redirect_ex)
        r_valid <= 1'b0;
      else if (!bus.stall_id)
        r_valid <= w_avail;
      if (w_load) begin
        r_instr <= w_head_data;
        r_npc   <= w_head_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.imem_addr               = r_pc;
  assign bus.instruction_if          = r_instr;
  assign bus.next_program_counter_if = r_npc;
  assign bus.branch_prediction_bp    = !r_valid;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !w_overflow);

endmodule
